// File: rtl/team_06_feeder_pkg.sv
// Shared types and constants for the DAC sample feeder.
package team_06_feeder_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] IDLE_SAMPLE_DEFAULT = 8'h80;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } feeder_state_t;

endpackage

// File: rtl/team_06_sample_fifo.sv
// Sample FIFO: occupancy-based full/empty, naturally wrapping pointers.
module team_06_sample_fifo
    import team_06_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  sample_t                      data_i,
    output sample_t                      data_o,
    output logic                         ready_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    sample_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ready_q, ready_d;
    logic               empty_q, empty_d;
    logic               push_ok_c;
    logic               pop_ok_c;

    // Qualify requests against the registered full/empty flags.
    always_comb begin
        push_ok_c = push_i && ready_q;
        pop_ok_c  = pop_i && !empty_q;
    end

    // Next pointers, occupancy and the flags derived from it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign ready_o = ready_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/team_06_dac_sample_feeder.sv
// Frame-aligned sample feeder: buffers producer samples and presents one per frame.
module team_06_dac_sample_feeder
    import team_06_feeder_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FRAME_BITS  = 8,
    parameter int unsigned PRIME_LEVEL = 4,
    parameter logic [7:0]  IDLE_SAMPLE = IDLE_SAMPLE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         bit_tick,
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_data,
    output logic                         wr_ready,
    output logic [7:0]                   sample_out,
    output logic                         frame_start,
    output logic                         underflow,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    feeder_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    sample_t            sample_q, sample_d;
    logic               frame_start_q, frame_start_d;
    logic               underflow_q, underflow_d;

    logic               push_c;
    logic               pop_c;
    logic               boundary_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               fifo_ready;
    logic               fifo_empty;
    sample_t            fifo_head;
    logic [LVL_W-1:0]   fifo_level;

    team_06_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (wr_data),
        .data_o  (fifo_head),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Producer writes are accepted in every state whenever there is room.
    always_comb begin
        push_c     = wr_valid && fifo_ready;
        boundary_c = bit_tick && (cnt_q == CNT_W'(FRAME_BITS - 1));
        cnt_inc_c  = (cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : cnt_q + CNT_W'(1);
    end

    // Next-state, frame counter and per-boundary sample selection.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sample_d      = sample_q;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;
        pop_c         = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sample_d = IDLE_SAMPLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = PRIME;
                    cnt_d    = '0;
                    sample_d = IDLE_SAMPLE;
                end
                PRIME: begin
                    if (bit_tick) begin
                        cnt_d = cnt_inc_c;
                    end
                    if (boundary_c) begin
                        frame_start_d = 1'b1;
                        if (!fifo_empty && (fifo_level >= LVL_W'(PRIME_LEVEL))) begin
                            pop_c    = 1'b1;
                            sample_d = fifo_head;
                            state_d  = RUN;
                        end else begin
                            sample_d = IDLE_SAMPLE;
                        end
                    end
                end
                RUN: begin
                    if (bit_tick) begin
                        cnt_d = cnt_inc_c;
                    end
                    if (boundary_c) begin
                        frame_start_d = 1'b1;
                        if (!fifo_empty) begin
                            pop_c    = 1'b1;
                            sample_d = fifo_head;
                        end else begin
                            sample_d    = IDLE_SAMPLE;
                            underflow_d = 1'b1;
                            state_d     = PRIME;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    sample_d = IDLE_SAMPLE;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sample_q      <= IDLE_SAMPLE;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sample_q      <= sample_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign wr_ready    = fifo_ready;
    assign sample_out  = sample_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign fill_level  = fifo_level;

endmodule

// File: tb/tb_team_06_dac_sample_feeder.sv
// Scoreboard bench for the DAC sample feeder: frame task queues the expected frame, monitor checks it.
module tb_team_06_dac_sample_feeder;

    localparam int unsigned TICK_SP = 8;

    typedef struct packed {
        logic       uf;
        logic [7:0] s;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       bit_tick;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] sample_out;
    logic       frame_start;
    logic       underflow;
    logic [4:0] fill_level;

    int   checks    = 0;
    int   failures  = 0;
    int   fs_count  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] prev_sample = 8'h80;

    team_06_dac_sample_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .bit_tick    (bit_tick),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .sample_out  (sample_out),
        .frame_start (frame_start),
        .underflow   (underflow),
        .fill_level  (fill_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every frame_start and guards sample stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_sample = sample_out;
        end else begin
            if (frame_start) begin
                fs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_unexpected actual=%0h expected=none t=%0t", sample_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_sample", 32'(sample_out), 32'(mon_e.s));
                    chk("frame_underflow", 32'(underflow), 32'(mon_e.uf));
                end
            end else if (underflow) begin
                checks++;
                failures++;
                $display("FAIL underflow_without_frame actual=1 expected=0 t=%0t", $time);
            end
            if ((sample_out != prev_sample) && !frame_start && en) begin
                checks++;
                failures++;
                $display("FAIL sample_stability actual=%0h expected=%0h t=%0t", sample_out, prev_sample, $time);
            end
            prev_sample = sample_out;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            repeat (TICK_SP - 1) cyc();
            bit_tick = 1'b1;
            cyc();
            bit_tick = 1'b0;
        end
    endtask

    // One full frame of ticks; optional write presented on the boundary edge.
    task automatic frame(input logic [7:0] s, input logic uf, input logic bpush, input logic [7:0] bdata);
        int start;
        exp_t e;
        e.s  = s;
        e.uf = uf;
        exp_q.push_back(e);
        start = fs_count;
        ticks(7);
        repeat (TICK_SP - 1) cyc();
        chk("no_early_boundary", 32'(fs_count), 32'(start));
        if (bpush) begin
            wr_valid = 1'b1;
            wr_data  = bdata;
        end
        bit_tick = 1'b1;
        cyc();
        bit_tick = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("one_boundary_per_frame", 32'(fs_count), 32'(start + 1));
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        bit_tick = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        repeat (3) cyc();
        chk("reset_sample", 32'(sample_out), 32'h80);
        chk("reset_wr_ready", 32'(wr_ready), 32'h1);
        chk("reset_fill", 32'(fill_level), 32'h0);
        chk("reset_frame_start", 32'(frame_start), 32'h0);
        chk("reset_underflow", 32'(underflow), 32'h0);
        rst = 1'b0;
        cyc();

        // Prime with four samples and stream them out.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("fill_after_4", 32'(fill_level), 32'h4);
        en = 1'b1;
        cyc();
        frame(8'h11, 1'b0, 1'b0, 8'h00);
        frame(8'h22, 1'b0, 1'b0, 8'h00);
        frame(8'h33, 1'b0, 1'b0, 8'h00);
        frame(8'h44, 1'b0, 1'b0, 8'h00);

        // Starved boundary, then refill and resume.
        frame(8'h80, 1'b1, 1'b0, 8'h00);
        push(8'h55);
        push(8'h66);
        push(8'h77);
        push(8'h88);
        frame(8'h55, 1'b0, 1'b0, 8'h00);

        // Drop enable mid-frame; FIFO contents survive.
        ticks(3);
        en = 1'b0;
        cyc();
        chk("disable_sample", 32'(sample_out), 32'h80);
        chk("disable_fill_kept", 32'(fill_level), 32'h3);
        push(8'h99);
        en = 1'b1;
        cyc();
        frame(8'h66, 1'b0, 1'b0, 8'h00);
        frame(8'h77, 1'b0, 1'b0, 8'h00);
        frame(8'h88, 1'b0, 1'b0, 8'h00);
        frame(8'h99, 1'b0, 1'b0, 8'h00);
        frame(8'h80, 1'b1, 1'b0, 8'h00);

        // Fill completely while disabled.
        en = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) begin
            push(8'hA0 + 8'(i));
        end
        chk("full_wr_ready", 32'(wr_ready), 32'h0);
        chk("full_fill", 32'(fill_level), 32'h10);
        push(8'hEE);
        chk("full_write_ignored", 32'(fill_level), 32'h10);
        en = 1'b1;
        cyc();
        frame(8'hA0, 1'b0, 1'b1, 8'hEE);
        chk("pop_from_full_fill", 32'(fill_level), 32'hF);
        chk("pop_from_full_ready", 32'(wr_ready), 32'h1);
        for (int i = 1; i < 16; i++) begin
            frame(8'hA0 + 8'(i), 1'b0, 1'b0, 8'h00);
        end
        chk("drained_fill", 32'(fill_level), 32'h0);

        // Write into an empty FIFO on the boundary edge: no fall-through.
        frame(8'h80, 1'b1, 1'b1, 8'h5A);
        chk("boundary_push_fill", 32'(fill_level), 32'h1);
        frame(8'h80, 1'b0, 1'b0, 8'h00);
        chk("below_prime_fill", 32'(fill_level), 32'h1);
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        frame(8'h5A, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a running frame.
        ticks(3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sample", 32'(sample_out), 32'h80);
        chk("async_rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("async_rst_fill", 32'(fill_level), 32'h0);
        chk("async_rst_underflow", 32'(underflow), 32'h0);
        chk("async_rst_frame_start", 32'(frame_start), 32'h0);
        en = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (4) cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
